burst_channel: RTL and testbench

Parametrised, synthesizable noisy-channel model for the convolutional-encoder / Viterbi-decoder test path. It sits between encoder output and decoder input and XORs LFSR-driven error masks into SYM_W-bit symbols. Errors arrive either as isolated hits or as bursts of up to BURST_MAX consecutive corrupted symbols, confined to a configurable injection window. Optional counters report symbols, errored symbols and flipped bits for BER measurement.

---
 rtl/burst_channel_pkg.sv | 23 ++
 rtl/burst_channel_lfsr32.sv | 18 +
 rtl/burst_channel.sv | 142 ++++++++++++++
 tb/tb_burst_channel.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_channel_pkg.sv
// Shared types and helpers for the burst_channel noisy-channel model.
package channel_pkg;

    typedef enum logic {
        CLEAN = 1'b0,
        BURST = 1'b1
    } state_t;

    // Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + {31'b0, v[i]};
        return c;
    endfunction

endpackage

// File: rtl/burst_channel_lfsr32.sv
// 32-bit Galois LFSR; steps once per cycle with advance high.
module lfsr32
    import channel_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic [31:0] seed,
    output logic [31:0] state
);

    // Generator register, reloads seed on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         state <= seed;
        else if (advance) state <= lfsr_next(state);
    end

endmodule

// File: rtl/burst_channel.sv
// Noisy-channel model: XORs LFSR-driven error masks into coded symbols,
// as isolated hits or bursts, limited to an injection window.
// Define BURST_CHANNEL_STATS_EN to build the errored-symbol and
// flipped-bit counters; otherwise they read 0.
//
// state | meaning
// CLEAN | no burst in progress; each symbol may start a hit/burst
// BURST | burst_left more symbols will be corrupted
module burst_channel
    import channel_pkg::*;
#(
    parameter int          SYM_W     = 2,
    parameter int          RATE_BITS = 5,
    parameter int          THRESH    = 2,
    parameter int          BURST_MAX = 4,
    parameter int          WINDOW    = 256,
    parameter logic [31:0] SEED      = 32'h1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_enable,
    input  logic             clr_stats,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] in_sym,
    output logic             out_valid,
    output logic [SYM_W-1:0] out_sym,
    output logic [SYM_W-1:0] out_err_mask,
    output logic [31:0]      sym_count,
    output logic [31:0]      err_sym_count,
    output logic [31:0]      err_bit_count
);

    // An all-zero LFSR would lock up, so a zero seed becomes 1
    localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [7:0]  BURST_AND = 8'(BURST_MAX - 1);

    logic [31:0]      lfsr;
    state_t           state, state_next;
    logic [7:0]       burst_left, burst_next;
    logic             inj_ok, hit, corrupt;
    logic [SYM_W-1:0] mask_raw, mask;
    logic             unused_bits;

    lfsr32 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (in_valid),
        .seed    (SEED_EFF),
        .state   (lfsr)
    );

    // Window uses the registered (pre-increment) symbol count
    assign inj_ok   = cfg_enable && ((WINDOW == 0) || (sym_count < 32'(WINDOW)));
    assign hit      = 32'(lfsr[RATE_BITS-1:0]) < 32'(THRESH);
    assign mask_raw = lfsr[SYM_W+7:8];
    assign mask     = !corrupt ? '0 : ((mask_raw == '0) ? SYM_W'(1) : mask_raw);
    // Only some LFSR bits feed slices; fold the rest away
    assign unused_bits = ^lfsr;

    // Next-state decode for the burst FSM
    always_comb begin
        corrupt    = 1'b0;
        burst_next = burst_left;
        state_next = state;
        case (state)
            CLEAN: begin
                if (inj_ok && hit) begin
                    corrupt    = 1'b1;
                    burst_next = lfsr[23:16] & BURST_AND;
                    state_next = (burst_next != 8'd0) ? BURST : CLEAN;
                end
            end
            BURST: begin
                if (!inj_ok) begin
                    burst_next = 8'd0;
                    state_next = CLEAN;
                end else begin
                    corrupt    = 1'b1;
                    burst_next = burst_left - 8'd1;
                    state_next = (burst_left == 8'd1) ? CLEAN : BURST;
                end
            end
            default: begin
                burst_next = 8'd0;
                state_next = CLEAN;
            end
        endcase
    end

    // FSM state and registered symbol outputs; everything holds on bubbles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= CLEAN;
            burst_left   <= 8'd0;
            out_valid    <= 1'b0;
            out_sym      <= '0;
            out_err_mask <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                state        <= state_next;
                burst_left   <= burst_next;
                out_sym      <= in_sym ^ mask;
                out_err_mask <= mask;
            end
        end
    end

    // Accepted-symbol count, needed for the window even without stats
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                        sym_count <= '0;
        else if (clr_stats)                              sym_count <= '0;
        else if (in_valid && sym_count != 32'hFFFF_FFFF) sym_count <= sym_count + 32'd1;
    end

`ifdef BURST_CHANNEL_STATS_EN
    logic [31:0] mask_bits;
    logic [32:0] bit_sum;

    assign mask_bits = popcount(32'(mask));
    assign bit_sum   = {1'b0, err_bit_count} + {1'b0, mask_bits};

    // Saturating error statistics; a clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_sym_count <= '0;
            err_bit_count <= '0;
        end else if (clr_stats) begin
            err_sym_count <= '0;
            err_bit_count <= '0;
        end else if (in_valid) begin
            if (mask != '0 && err_sym_count != 32'hFFFF_FFFF)
                err_sym_count <= err_sym_count + 32'd1;
            err_bit_count <= bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];
        end
    end
`else
    assign err_sym_count = '0;
    assign err_bit_count = '0;
`endif

endmodule

// File: tb/tb_burst_channel.sv
// Self-checking bench for burst_channel: three differently parameterised
// instances share one stimulus stream and are checked against a
// behavioural model of the channel.
module tb_burst_channel;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_enable = 1'b0;
    logic       clr_stats = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_sym = 2'b00;

    logic        o_ov   [3];
    logic [1:0]  o_sym  [3];
    logic [1:0]  o_mask [3];
    logic [31:0] o_sc   [3];
    logic [31:0] o_es   [3];
    logic [31:0] o_eb   [3];

    int          p_thr  [3] = '{2, 32, 32};
    int          p_win  [3] = '{256, 0, 8};
    int          p_bmax [3] = '{4, 8, 4};
    logic [31:0] p_seed [3] = '{32'h1, 32'hACE1, 32'h0};

    logic [31:0] m_lfsr [3];
    int          m_bl   [3];
    longint      m_sc   [3];
    longint      m_es   [3];
    longint      m_eb   [3];
    logic        m_ov   [3];
    logic [1:0]  m_os   [3];
    logic [1:0]  m_om   [3];

    int n_cmp = 0;
    int n_bad = 0;
    bit stats_on;
    logic [1:0] q_power [12];

    always #5 clk = ~clk;

    burst_channel #(.THRESH(2), .WINDOW(256), .BURST_MAX(4), .SEED(32'h1)) dut0 (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_sym(in_sym), .out_valid(o_ov[0]), .out_sym(o_sym[0]),
        .out_err_mask(o_mask[0]), .sym_count(o_sc[0]), .err_sym_count(o_es[0]),
        .err_bit_count(o_eb[0]));

    burst_channel #(.THRESH(32), .WINDOW(0), .BURST_MAX(8), .SEED(32'hACE1)) dut1 (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_sym(in_sym), .out_valid(o_ov[1]), .out_sym(o_sym[1]),
        .out_err_mask(o_mask[1]), .sym_count(o_sc[1]), .err_sym_count(o_es[1]),
        .err_bit_count(o_eb[1]));

    burst_channel #(.THRESH(32), .WINDOW(8), .BURST_MAX(4), .SEED(32'h0)) dut2 (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_sym(in_sym), .out_valid(o_ov[2]), .out_sym(o_sym[2]),
        .out_err_mask(o_mask[2]), .sym_count(o_sc[2]), .err_sym_count(o_es[2]),
        .err_bit_count(o_eb[2]));

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_lfsr[i] = (p_seed[i] == 0) ? 32'h1 : p_seed[i];
            m_bl[i] = 0;
            m_sc[i] = 0; m_es[i] = 0; m_eb[i] = 0;
            m_ov[i] = 0; m_os[i] = 0; m_om[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit ok, bad;
            logic [1:0] mk;
            m_ov[i] = in_valid;
            if (in_valid) begin
                ok  = cfg_enable && (p_win[i] == 0 || m_sc[i] < longint'(p_win[i]));
                bad = 0;
                if (m_bl[i] > 0) begin
                    if (ok) begin bad = 1; m_bl[i] = m_bl[i] - 1; end
                    else m_bl[i] = 0;
                end else if (ok && int'(m_lfsr[i] % 32) < p_thr[i]) begin
                    bad = 1;
                    m_bl[i] = int'((m_lfsr[i] >> 16) % 256) % p_bmax[i];
                end
                mk = 2'((m_lfsr[i] >> 8) % 4);
                if (mk == 0) mk = 2'd1;
                if (!bad) mk = 2'd0;
                m_os[i] = in_sym ^ mk;
                m_om[i] = mk;
                if (!clr_stats) begin
                    if (m_sc[i] < 64'hFFFF_FFFF) m_sc[i] = m_sc[i] + 1;
                    if (mk != 0 && m_es[i] < 64'hFFFF_FFFF) m_es[i] = m_es[i] + 1;
                    m_eb[i] = m_eb[i] + $countones(mk);
                    if (m_eb[i] > 64'hFFFF_FFFF) m_eb[i] = 64'hFFFF_FFFF;
                end
                m_lfsr[i] = (m_lfsr[i] >> 1) ^ (m_lfsr[i][0] ? 32'h80200003 : 32'h0);
            end
            if (clr_stats) begin m_sc[i] = 0; m_es[i] = 0; m_eb[i] = 0; end
        end
    endtask

    task automatic cycle(input bit v, input logic [1:0] s, input bit clr);
        in_valid = v; in_sym = s; clr_stats = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; clr_stats = 0;
        rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (o_ov[i] !== 1'b0 || o_sym[i] !== 2'b00 || o_mask[i] !== 2'b00 ||
                o_sc[i] !== 32'd0 || o_es[i] !== 32'd0 || o_eb[i] !== 32'd0) begin
                n_bad++;
                $display("FAIL reset inst%0d: got ov=%b sym=%b mask=%b sc=%0d es=%0d eb=%0d expected all 0",
                         i, o_ov[i], o_sym[i], o_mask[i], o_sc[i], o_es[i], o_eb[i]);
            end
        end
    endtask

    task automatic test_transparent();
        do_reset();
        cfg_enable = 0;
        for (int k = 0; k < 100; k++) begin
            cycle(1, 2'b10, 0);
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (o_ov[i] !== 1'b1 || o_sym[i] !== 2'b10 || o_mask[i] !== 2'b00) begin
                    n_bad++;
                    $display("FAIL transparent inst%0d k=%0d: got ov=%b sym=%b mask=%b expected 1/10/00",
                             i, k, o_ov[i], o_sym[i], o_mask[i]);
                end
            end
        end
        cycle(0, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (o_sc[i] !== 32'd100 || o_es[i] !== 32'd0 || o_eb[i] !== 32'd0 || o_ov[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL transparent_counts inst%0d: got sc=%0d es=%0d eb=%0d ov=%b expected 100/0/0/0",
                         i, o_sc[i], o_es[i], o_eb[i], o_ov[i]);
            end
        end
    endtask

    task automatic test_window();
        longint exp_es1, exp_eb1, exp_es2;
        do_reset();
        cfg_enable = 1;
        for (int k = 0; k < 50; k++) begin
            cycle(1, 2'($urandom_range(0, 3)), 0);
            if (k < 12) q_power[k] = o_mask[1];
            n_cmp++;
            if (o_mask[1] === 2'b00 || o_mask[1] !== m_om[1] || o_sym[1] !== m_os[1]) begin
                n_bad++;
                $display("FAIL always_hit k=%0d: got mask=%b sym=%b expected mask=%b sym=%b",
                         k, o_mask[1], o_sym[1], m_om[1], m_os[1]);
            end
            n_cmp++;
            if ((k < 8) ? (o_mask[2] === 2'b00 || o_mask[2] !== m_om[2]) : (o_mask[2] !== 2'b00)) begin
                n_bad++;
                $display("FAIL window k=%0d: got mask=%b expected %s", k, o_mask[2],
                         (k < 8) ? "nonzero" : "00");
            end
        end
        cycle(0, 2'b00, 0);
        exp_es1 = stats_on ? 50 : 0;
        exp_eb1 = stats_on ? m_eb[1] : 0;
        exp_es2 = stats_on ? 8 : 0;
        n_cmp++;
        if (o_es[1] !== 32'(exp_es1) || o_eb[1] !== 32'(exp_eb1) ||
            (stats_on && (o_eb[1] < 50 || o_eb[1] > 100))) begin
            n_bad++;
            $display("FAIL always_hit_counts: got es=%0d eb=%0d expected es=%0d eb=%0d",
                     o_es[1], o_eb[1], exp_es1, exp_eb1);
        end
        n_cmp++;
        if (o_es[2] !== 32'(exp_es2) || o_sc[2] !== 32'd50) begin
            n_bad++;
            $display("FAIL window_counts: got es=%0d sc=%0d expected es=%0d sc=50",
                     o_es[2], o_sc[2], exp_es2);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cfg_enable = ($urandom_range(0, 19) != 0);
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 63) == 0);
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (o_ov[i] !== m_ov[i] || o_sym[i] !== m_os[i] || o_mask[i] !== m_om[i] ||
                    o_sc[i] !== 32'(m_sc[i]) || o_es[i] !== (stats_on ? 32'(m_es[i]) : 32'd0) ||
                    o_eb[i] !== (stats_on ? 32'(m_eb[i]) : 32'd0)) begin
                    n_bad++;
                    $display("FAIL random inst%0d k=%0d: got ov=%b sym=%b mask=%b sc=%0d es=%0d eb=%0d expected ov=%b sym=%b mask=%b sc=%0d es=%0d eb=%0d",
                             i, k, o_ov[i], o_sym[i], o_mask[i], o_sc[i], o_es[i], o_eb[i],
                             m_ov[i], m_os[i], m_om[i], m_sc[i],
                             stats_on ? m_es[i] : 0, stats_on ? m_eb[i] : 0);
                end
            end
        end
    endtask

    task automatic test_gapped();
        logic [1:0] syms  [40];
        logic [1:0] g_sym [3][40];
        logic [1:0] g_msk [3][40];
        for (int k = 0; k < 40; k++) syms[k] = 2'($urandom_range(0, 3));
        do_reset();
        cfg_enable = 1;
        for (int k = 0; k < 40; k++) begin
            cycle(1, syms[k], 0);
            for (int i = 0; i < 3; i++) begin
                g_sym[i][k] = o_sym[i];
                g_msk[i][k] = o_mask[i];
                n_cmp++;
                if (o_ov[i] !== 1'b1 || o_mask[i] !== m_om[i] || o_sym[i] !== m_os[i]) begin
                    n_bad++;
                    $display("FAIL gapped inst%0d k=%0d: got ov=%b mask=%b sym=%b expected 1/%b/%b",
                             i, k, o_ov[i], o_mask[i], o_sym[i], m_om[i], m_os[i]);
                end
            end
            repeat ($urandom_range(0, 2)) begin
                cycle(0, 2'($urandom_range(0, 3)), 0);
                for (int i = 0; i < 3; i++) begin
                    n_cmp++;
                    if (o_ov[i] !== 1'b0 || o_mask[i] !== g_msk[i][k] || o_sym[i] !== g_sym[i][k]) begin
                        n_bad++;
                        $display("FAIL bubble_hold inst%0d k=%0d: got ov=%b mask=%b sym=%b expected 0/%b/%b",
                                 i, k, o_ov[i], o_mask[i], o_sym[i], g_msk[i][k], g_sym[i][k]);
                    end
                end
            end
        end
        do_reset();
        for (int k = 0; k < 40; k++) begin
            cycle(1, syms[k], 0);
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (o_mask[i] !== g_msk[i][k] || o_sym[i] !== g_sym[i][k]) begin
                    n_bad++;
                    $display("FAIL gap_vs_b2b inst%0d k=%0d: got mask=%b sym=%b expected %b/%b",
                             i, k, o_mask[i], o_sym[i], g_msk[i][k], g_sym[i][k]);
                end
            end
        end
    endtask

    task automatic test_clr();
        do_reset();
        cfg_enable = 1;
        for (int k = 0; k < 10; k++) cycle(1, 2'($urandom_range(0, 3)), 0);
        cycle(1, 2'($urandom_range(0, 3)), 1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (o_sc[i] !== 32'd0 || o_es[i] !== 32'd0 || o_eb[i] !== 32'd0) begin
                n_bad++;
                $display("FAIL clr inst%0d: got sc=%0d es=%0d eb=%0d expected 0/0/0",
                         i, o_sc[i], o_es[i], o_eb[i]);
            end
        end
        cycle(1, 2'($urandom_range(0, 3)), 0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (o_sc[i] !== 32'd1 || o_es[i] !== (stats_on ? 32'(m_es[i]) : 32'd0) ||
                o_mask[i] !== m_om[i]) begin
                n_bad++;
                $display("FAIL after_clr inst%0d: got sc=%0d es=%0d mask=%b expected sc=1 es=%0d mask=%b",
                         i, o_sc[i], o_es[i], o_mask[i], stats_on ? m_es[i] : 0, m_om[i]);
            end
        end
    endtask

    task automatic test_reset_midburst();
        bit in_burst;
        do_reset();
        cfg_enable = 1;
        in_burst = 0;
        for (int k = 0; k < 40 && !in_burst; k++) begin
            cycle(1, 2'($urandom_range(0, 3)), 0);
            in_burst = (m_bl[1] > 0);
        end
        n_cmp++;
        if (!in_burst) begin
            n_bad++;
            $display("FAIL burst_start: got no burst in 40 symbols expected a burst");
        end
        in_valid = 0;
        #3 rst = 0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (o_ov[i] !== 1'b0 || o_sym[i] !== 2'b00 || o_mask[i] !== 2'b00 || o_sc[i] !== 32'd0) begin
                n_bad++;
                $display("FAIL midburst_reset inst%0d: got ov=%b sym=%b mask=%b sc=%0d expected 0",
                         i, o_ov[i], o_sym[i], o_mask[i], o_sc[i]);
            end
        end
        @(posedge clk);
        #3 rst = 1;
        for (int k = 0; k < 12; k++) begin
            cycle(1, 2'($urandom_range(0, 3)), 0);
            n_cmp++;
            if (o_mask[1] !== q_power[k] || o_mask[1] !== m_om[1]) begin
                n_bad++;
                $display("FAIL post_reset_seq k=%0d: got mask=%b expected %b", k, o_mask[1], q_power[k]);
            end
        end
    endtask

    initial begin
`ifdef BURST_CHANNEL_STATS_EN
        stats_on = 1;
`else
        stats_on = 0;
`endif
        model_reset();
        test_reset();
        test_transparent();
        test_window();
        test_random();
        test_gapped();
        test_clr();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
